// File: rtl/gpio_pulpino_endpoint_if.sv
// Bus bundle between the GPIO endpoint and its surroundings: io-side byte handshakes in both
// directions plus the PULPino-side word streams and TX status.
interface gpio_pulpino_endpoint_if;
  logic [7:0]  gpio_data_in;
  logic [1:0]  data_in_io_turn;
  logic [1:0]  data_in_pulpino_turn;
  logic [31:0] rx_word;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  gpio_data_out;
  logic [1:0]  data_out_pulpino_turn;
  logic [1:0]  data_out_io_turn;
  logic [31:0] tx_word;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_done;
  logic        tx_error;
  logic        err_clr;

  modport slave (
    input  gpio_data_in, data_in_io_turn, rx_ready, data_out_io_turn, tx_word, tx_valid,
           err_clr,
    output data_in_pulpino_turn, rx_word, rx_valid, gpio_data_out, data_out_pulpino_turn,
           tx_ready, tx_done, tx_error
  );

  modport master (
    output gpio_data_in, data_in_io_turn, rx_ready, data_out_io_turn, tx_word, tx_valid,
           err_clr,
    input  data_in_pulpino_turn, rx_word, rx_valid, gpio_data_out, data_out_pulpino_turn,
           tx_ready, tx_done, tx_error
  );
endinterface

// File: rtl/gpio_pulpino_endpoint.sv
// Byte-wise token handshake bridge between an io side (USB) and PULPino: assembles 4 received
// bytes into a word and serialises transmit words into 4 acknowledged bytes.
module gpio_pulpino_endpoint #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                    clk,
  input logic                    reset_i,
  gpio_pulpino_endpoint_if.slave bus
);

  typedef enum logic [1:0] {TxIdle, TxSetup, TxWait} tx_state_e;

  localparam int unsigned SyncW       = 12;
  localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES) - 32'd1;

  // Input synchroniser: io data and both io tokens travel together through the same stages.
  logic [SyncW-1:0] sync_q [SYNC_STAGES];
  logic [SyncW-1:0] sync_d [SYNC_STAGES];
  logic [7:0]       in_data_s;
  logic [1:0]       in_tok_s;
  logic [1:0]       out_ack_s;

  always_comb begin
    sync_d[0] = {bus.gpio_data_in, bus.data_in_io_turn, bus.data_out_io_turn};
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign {in_data_s, in_tok_s, out_ack_s} = sync_q[SYNC_STAGES-1];

  // RX path
  logic [31:0] rx_word_q, rx_word_d;
  logic        rx_valid_q, rx_valid_d;
  logic [1:0]  rx_cnt_q, rx_cnt_d;
  logic [1:0]  in_turn_q, in_turn_d;
  logic        rx_new;
  logic        rx_room;

  assign rx_new  = ((in_tok_s == 2'b01) || (in_tok_s == 2'b10)) && (in_tok_s != in_turn_q);
  assign rx_room = !rx_valid_q || bus.rx_ready;

  always_comb begin
    rx_word_d  = rx_word_q;
    rx_valid_d = rx_valid_q;
    rx_cnt_d   = rx_cnt_q;
    in_turn_d  = in_turn_q;
    if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (in_tok_s == 2'b00) begin
      // Abort drops the partial word only; a completed word waiting for the consumer survives.
      rx_cnt_d  = 2'd0;
      in_turn_d = 2'b00;
    end else if (rx_new && rx_room) begin
      rx_word_d[{rx_cnt_q, 3'b000} +: 8] = in_data_s;
      in_turn_d = in_tok_s;
      rx_cnt_d  = rx_cnt_q + 2'd1;
      if (rx_cnt_q == 2'd3) begin
        rx_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      rx_word_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_cnt_q   <= 2'd0;
      in_turn_q  <= 2'b00;
    end else begin
      rx_word_q  <= rx_word_d;
      rx_valid_q <= rx_valid_d;
      rx_cnt_q   <= rx_cnt_d;
      in_turn_q  <= in_turn_d;
    end
  end

  // TX path
  tx_state_e   tx_state_q, tx_state_d;
  logic [31:0] tx_word_q, tx_word_d;
  logic [1:0]  tx_byte_q, tx_byte_d;
  logic [1:0]  byte_nxt;
  logic [7:0]  out_data_q, out_data_d;
  logic [1:0]  out_turn_q, out_turn_d;
  logic [1:0]  next_tok_q, next_tok_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        tx_done_q, tx_done_d;
  logic        tx_error_q, tx_error_d;

  assign byte_nxt = tx_byte_q + 2'd1;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_word_d  = tx_word_q;
    tx_byte_d  = tx_byte_q;
    out_data_d = out_data_q;
    out_turn_d = out_turn_q;
    next_tok_d = next_tok_q;
    wait_cnt_d = wait_cnt_q;
    tx_done_d  = 1'b0;
    tx_error_d = tx_error_q && !bus.err_clr;
    unique case (tx_state_q)
      TxIdle: begin
        if (bus.tx_valid) begin
          tx_word_d  = bus.tx_word;
          out_data_d = bus.tx_word[7:0];
          tx_byte_d  = 2'd0;
          tx_state_d = TxSetup;
        end
      end
      TxSetup: begin
        // Data has been stable for a cycle; now publish the token (01 and 10 alternate).
        out_turn_d = next_tok_q;
        next_tok_d = ~next_tok_q;
        wait_cnt_d = '0;
        tx_state_d = TxWait;
      end
      TxWait: begin
        if (out_ack_s == out_turn_q) begin
          if (tx_byte_q == 2'd3) begin
            tx_done_d  = 1'b1;
            tx_state_d = TxIdle;
          end else begin
            tx_byte_d  = byte_nxt;
            out_data_d = tx_word_q[{byte_nxt, 3'b000} +: 8];
            tx_state_d = TxSetup;
          end
        end else if (TimeoutEn && (wait_cnt_q == TimeoutLast)) begin
          tx_error_d = 1'b1;
          out_turn_d = 2'b00;
          next_tok_d = 2'b01;
          tx_state_d = TxIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      tx_state_q <= TxIdle;
      tx_word_q  <= '0;
      tx_byte_q  <= 2'd0;
      out_data_q <= '0;
      out_turn_q <= 2'b00;
      next_tok_q <= 2'b01;
      wait_cnt_q <= '0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_word_q  <= tx_word_d;
      tx_byte_q  <= tx_byte_d;
      out_data_q <= out_data_d;
      out_turn_q <= out_turn_d;
      next_tok_q <= next_tok_d;
      wait_cnt_q <= wait_cnt_d;
      tx_done_q  <= tx_done_d;
      tx_error_q <= tx_error_d;
    end
  end

  assign bus.data_in_pulpino_turn  = in_turn_q;
  assign bus.rx_word               = rx_word_q;
  assign bus.rx_valid              = rx_valid_q;
  assign bus.gpio_data_out         = out_data_q;
  assign bus.data_out_pulpino_turn = out_turn_q;
  assign bus.tx_ready              = (tx_state_q == TxIdle);
  assign bus.tx_done               = tx_done_q;
  assign bus.tx_error              = tx_error_q;

endmodule
